inv_permute_unit: RTL and testbench

Streaming inverse of the Keccak ρ-free π slice permutation. It accepts the 64 permuted 25-bit slices of one state block over a valid/ready input. Each slice is restored to pre-permutation order, and the result streams out through a 2-entry output buffer tagged with block and line indices. It sits on the write side of the permute datapath so that stored permute outputs can be read back and checked or undone.

---
 rtl/inv_permute_if.sv | 36 +++
 rtl/inv_permute_unit.sv | 154 +++++++++++++++
 tb/tb_inv_permute_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/inv_permute_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_permute_if
// Description : Handshake/bus bundle for inv_permute_unit. The slave modport
//               is the unit's view; the master modport is the producer /
//               consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface inv_permute_if #(
  parameter int LINE_W = 6,
  parameter int ID_W   = 10
);
  logic              start;
  logic [ID_W-1:0]   block_id;
  logic              in_valid;
  logic [24:0]       in_data;
  logic              in_ready;
  logic              out_valid;
  logic [24:0]       out_data;
  logic [LINE_W-1:0] out_line;
  logic [ID_W-1:0]   out_block;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, block_id, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_line, out_block, busy, done
  );

  modport slave (
    input  start, block_id, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_line, out_block, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/inv_permute_unit.sv
`default_nettype none
// ============================================================================
// Module      : inv_permute_unit
// Description : Streaming inverse of the Keccak pi slice permutation. Takes
//               the SLICES permuted 25-bit slices of one block, undoes pi on
//               each, and streams them out of a 2-entry buffer tagged with
//               line and block indices. SLICES must equal 2**LINE_W.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_permute_unit #(
  parameter int SLICES = 64,
  parameter int LINE_W = 6,
  parameter int ID_W   = 10
) (
  input  logic            clk,
  input  logic            rst,
  inv_permute_if.slave    bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  localparam logic [LINE_W:0]   c_IN_FULL   = (LINE_W+1)'(SLICES);
  localparam logic [LINE_W:0]   c_IN_LAST   = (LINE_W+1)'(SLICES - 1);
  localparam logic [LINE_W-1:0] c_LAST_LINE = LINE_W'(SLICES - 1);
  localparam int                c_ENT_W     = LINE_W + 25;

  // out[x][y] = in[y][(2*(x-y)) mod 5]; bit 5*y+x holds lane (x,y).
  // The +10 keeps the modulo operand non-negative.
  function automatic logic [24:0] inv_pi(input logic [24:0] s);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y+x] = s[5*((2*(x-y)+10)%5)+y];
      end
    end
    return r;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [LINE_W:0]    in_cnt_q, in_cnt_d;
  logic [LINE_W-1:0]  out_cnt_q, out_cnt_d;
  logic [ID_W-1:0]    blk_q, blk_d;
  logic               done_q, done_d;

  logic [c_ENT_W-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         cnt_q;

  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;
  logic [c_ENT_W-1:0] head;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q == c_ST_RUN) && (in_cnt_q != c_IN_FULL) && (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;
  assign head      = mem_q[rd_ptr_q];

  // Stale entries are masked so an empty buffer presents zeros.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? head[24:0] : 25'd0;
  assign bus.out_line  = out_valid ? head[c_ENT_W-1:25] : '0;
  assign bus.out_block = blk_q;
  assign bus.busy      = (state_q != c_ST_IDLE);
  assign bus.done      = done_q;

  // Next-state logic for the block FSM and its slice counters.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    blk_d     = blk_q;
    done_d    = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (bus.start) begin
          blk_d     = bus.block_id;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        if (push) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == c_IN_LAST) begin
            state_d = c_ST_DRAIN;
          end
        end
      end
      c_ST_DRAIN: begin
      end
      default: state_d = c_ST_IDLE;
    endcase
    // The last line can only pop in DRAIN, since pushing it moves us there.
    if (pop) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if ((out_cnt_q == c_LAST_LINE) && (state_q == c_ST_DRAIN)) begin
        state_d = c_ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // FSM, counter and block-tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      blk_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      blk_q     <= blk_d;
      done_q    <= done_d;
    end
  end

  // Two-entry buffer; each entry holds {line, inverse-permuted slice}.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_cnt_q[LINE_W-1:0], inv_pi(bus.in_data)};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_permute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_permute_unit
// Description : Directed self-checking bench for inv_permute_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_permute_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [24:0] in_vec  [64];
  logic [24:0] exp_vec [64];

  inv_permute_if #(.LINE_W(6), .ID_W(10)) bus ();

  inv_permute_unit #(.SLICES(64), .LINE_W(6), .ID_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forward pi: fwd[x][y] = in[(x+3y) mod 5][x]
  function automatic logic [24:0] fwd_pi(input logic [24:0] s);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = s[5*x + ((x+3*y)%5)];
    return r;
  endfunction

  task automatic build(input bit onehot);
    logic [24:0] orig;
    for (int i = 0; i < 64; i++) begin
      orig       = 25'($urandom);
      in_vec[i]  = fwd_pi(orig);
      exp_vec[i] = orig;
    end
    if (onehot) begin
      in_vec[0] = 25'd1 << 1;  exp_vec[0] = 25'd1 << 6;
      in_vec[1] = 25'd1 << 2;  exp_vec[1] = 25'd1 << 12;
      in_vec[2] = 25'd1 << 5;  exp_vec[2] = 25'd1 << 3;
      in_vec[3] = 25'd1 << 0;  exp_vec[3] = 25'd1 << 0;
    end
  endtask

  // mode 0: out_ready always 1, spurious start(block_id=5) at cycle 10.
  // mode 1: out_ready low for cycles 1..5, then low every third cycle.
  // stop_at > 0: stop after that many accepted slices (block left partial).
  task automatic stream_block(input logic [9:0] id, input int stop_at, input int mode);
    int in_idx, out_idx, cyc, done_seen, first_pop, last_pop;
    bit acc, popd;
    in_idx = 0; out_idx = 0; done_seen = 0; first_pop = -1; last_pop = -1;
    bus.start = 1'b1; bus.block_id = id; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    cyc = 1;
    while (cyc < 400) begin
      if (stop_at > 0 && in_idx == stop_at) break;
      if (out_idx == 64) begin
        chk("done_after_last_pop", 32'(bus.done), 32'd1);
        chk("busy_fall_with_done", 32'(bus.busy), 32'd0);
        chk("no_early_done", 32'(done_seen), 32'd0);
        if (mode == 0) begin
          chk("done_cycle", 32'(cyc), 32'd66);
          chk("first_pop_cycle", 32'(first_pop), 32'd2);
          chk("consecutive_pops", 32'(last_pop - first_pop), 32'd63);
        end
        break;
      end
      if (bus.done) done_seen++;
      if (mode == 1) bus.out_ready = (cyc > 5) && (cyc % 3 != 0);
      else           bus.out_ready = 1'b1;
      if (mode == 0 && cyc == 10) begin
        bus.start = 1'b1; bus.block_id = 10'd5;
      end else begin
        bus.start = 1'b0;
      end
      bus.in_valid = (in_idx < 64) && (stop_at == 0 || in_idx < stop_at);
      bus.in_data  = (in_idx < 64) ? in_vec[in_idx] : 25'd0;
      if (mode == 1 && cyc == 2) chk("bp_in_ready_one_entry", 32'(bus.in_ready), 32'd1);
      if (mode == 1 && cyc >= 3 && cyc <= 5) begin
        chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
        chk("bp_out_line_hold", 32'(bus.out_line), 32'd0);
        chk("bp_out_data_hold", 32'(bus.out_data), 32'(exp_vec[0]));
      end
      acc  = bus.in_valid & bus.in_ready;
      popd = bus.out_valid & bus.out_ready;
      if (popd) begin
        chk("out_data", 32'(bus.out_data), 32'(exp_vec[out_idx]));
        chk("out_line", 32'(bus.out_line), 32'(out_idx));
        chk("out_block", 32'(bus.out_block), 32'(id));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        out_idx++;
      end
      if (acc) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    if (cyc >= 400) chk("stream_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({pfx, "_busy"},      32'(bus.busy),      32'd0);
    chk({pfx, "_done"},      32'(bus.done),      32'd0);
    chk({pfx, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({pfx, "_out_line"},  32'(bus.out_line),  32'd0);
    chk({pfx, "_out_block"}, 32'(bus.out_block), 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.block_id = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // in_valid while IDLE must produce nothing.
    bus.in_valid = 1'b1; bus.in_data = 25'h1ABCDEF;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
    bus.in_valid = 1'b0;

    // Full throughput, one-hot mapping vectors, mid-run start ignored.
    build(1'b1);
    stream_block(10'h2A5, 0, 0);

    // Back-to-back start in the done cycle is accepted; exercise backpressure.
    build(1'b0);
    stream_block(10'h013, 0, 1);

    // Reset after 20 slices discards the block.
    build(1'b0);
    stream_block(10'h155, 20, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", 32'(bus.done), 32'd0);
    chk("midrst_idle", 32'(bus.busy), 32'd0);

    // A fresh block completes normally, lines restarting at 0.
    build(1'b0);
    stream_block(10'h3C1, 0, 0);
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(bus.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
